gat_feat_reader: RTL and testbench

GAT_FEAT_READER -- requirements
Module: gat_feat_reader

---
 rtl/gat_feat_reader.sv | 206 ++++++++++++++++++++
 tb/tb_gat_feat_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gat_feat_reader.sv
`default_nettype none
// ============================================================================
//  Module      : gat_feat_reader
//  Description : Streams the whole GAT result buffer out of the feature BRAM
//                as an AXI-Stream-style word stream. Reads are credit-limited
//                so the output FIFO never overflows under any m_tready
//                pattern. When the FIFO is empty, a word returning from the
//                BRAM is presented straight on the output in the cycle it is
//                captured. This allows one word per cycle with a FIFO only
//                RD_LATENCY+1 deep.
//  Options     : GAT_FEAT_READER_ROWEND_EN - m_tuser flags the last word of
//                every row (index mod NUM_FEATURE_OUT == NUM_FEATURE_OUT-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module gat_feat_reader #(
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int RD_LATENCY         = 2,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int FIFO_DEPTH         = RD_LATENCY + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          m_tuser,
    output logic                          busy,
    output logic                          done
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [NEW_FEATURE_ADDR_W-1:0] c_LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RDY = 2'd1,
        S_READ     = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [NEW_FEATURE_ADDR_W-1:0] r_idx;
    logic [RD_LATENCY-1:0]         r_vld;
    logic [RD_LATENCY-1:0]         r_last_pipe;
    logic [NEW_FEATURE_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]         r_mem_last;
    logic [c_PTR_W-1:0]            r_wptr;
    logic [c_PTR_W-1:0]            r_rptr;
    logic [c_CNT_W-1:0]            r_cnt;
    logic                          r_done;

    logic               w_cap;
    logic               w_cap_last;
    logic               w_fifo_ne;
    logic               w_out_valid;
    logic               w_out_last;
    logic               w_hs;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic               w_is_last_idx;
    logic [c_CNT_W-1:0] w_inflight;
    logic [c_CNT_W-1:0] w_occ;

    assign w_cap         = r_vld[RD_LATENCY-1];
    assign w_cap_last    = r_last_pipe[RD_LATENCY-1];
    assign w_fifo_ne     = (r_cnt != '0);
    assign w_out_valid   = w_fifo_ne | w_cap;
    assign w_out_last    = w_fifo_ne ? r_mem_last[r_rptr] : w_cap_last;
    assign w_hs          = w_out_valid & m_tready;
    assign w_pop         = w_fifo_ne & m_tready;
    // A captured word skips the FIFO only when the FIFO is empty and the sink takes it now
    assign w_push        = w_cap & (w_fifo_ne | ~m_tready);
    assign w_is_last_idx = (r_idx == c_LAST_IDX);
    assign w_occ         = r_cnt + w_inflight;
    // Credit check ignores a same-cycle pop so occupancy never exceeds FIFO_DEPTH
    assign w_issue       = (r_state == S_READ) && (w_occ < c_CNT_W'(FIFO_DEPTH));

    assign feat_bram_addrb = {r_idx, 2'b00};
    assign m_tvalid        = w_out_valid;
    assign m_tdata         = w_fifo_ne ? r_mem[r_rptr] : (w_cap ? feat_bram_dout : '0);
    assign m_tlast         = w_out_valid & w_out_last;
    assign done            = r_done;

    // Count reads currently travelling through the BRAM pipeline
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            w_inflight = w_inflight + c_CNT_W'(r_vld[k]);
        end
    end

    // Next-state and busy decode
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:     if (start)                     w_state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: if (gat_ready)                 w_state_nxt = S_READ;
            S_READ:     if (w_issue && w_is_last_idx)  w_state_nxt = S_DRAIN;
            S_DRAIN:    if (w_hs && w_out_last)        w_state_nxt = S_IDLE;
            default:                                   w_state_nxt = S_IDLE;
        endcase
    end

    // State register, read index, done pulse and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_done      <= 1'b0;
            r_vld       <= '0;
            r_last_pipe <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_done         <= (r_state == S_DRAIN) && w_hs && w_out_last;
            r_vld[0]       <= w_issue;
            r_last_pipe[0] <= w_issue && w_is_last_idx;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld[k]       <= r_vld[k-1];
                r_last_pipe[k] <= r_last_pipe[k-1];
            end
            if (w_issue && !w_is_last_idx) begin
                r_idx <= r_idx + 1'b1;
            end else if ((r_state == S_DRAIN) && (w_state_nxt == S_IDLE)) begin
                r_idx <= '0;
            end
        end
    end

    // FIFO pointers, occupancy and last-flag storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_mem_last <= '0;
        end else begin
            if (w_push) begin
                r_mem_last[r_wptr] <= w_cap_last;
                r_wptr             <= (r_wptr == c_PTR_MAX) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_MAX) ? '0 : r_rptr + 1'b1;
            end
            r_cnt <= r_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // FIFO data storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= feat_bram_dout;
        end
    end

`ifdef GAT_FEAT_READER_ROWEND_EN
    localparam int c_COL_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(NUM_FEATURE_OUT - 1);

    logic [c_COL_W-1:0]    r_col;
    logic [RD_LATENCY-1:0] r_user_pipe;
    logic [FIFO_DEPTH-1:0] r_mem_user;
    logic                  w_row_end;

    assign w_row_end = (r_col == c_COL_LAST);
    assign m_tuser   = w_out_valid & (w_fifo_ne ? r_mem_user[r_rptr] : r_user_pipe[RD_LATENCY-1]);

    // Column position of the next issued word; the row-end flag rides with the read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_user_pipe <= '0;
            r_mem_user  <= '0;
        end else begin
            r_user_pipe[0] <= w_issue && w_row_end;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_user_pipe[k] <= r_user_pipe[k-1];
            end
            if (w_push) begin
                r_mem_user[r_wptr] <= r_user_pipe[RD_LATENCY-1];
            end
            if (w_issue) begin
                r_col <= w_row_end ? '0 : r_col + 1'b1;
            end else if (r_state == S_IDLE) begin
                r_col <= '0;
            end
        end
    end
`else
    assign m_tuser = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gat_feat_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gat_feat_reader
//  Description : Directed self-checking bench for gat_feat_reader with a
//                3x4-word buffer and a two-cycle BRAM model returning
//                0xA000_0000 + word index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gat_feat_reader;

    localparam int NSG   = 3;
    localparam int NFO   = 4;
    localparam int LAT   = 2;
    localparam int W     = 32;
    localparam int DEPTH = NSG * NFO;
    localparam int AW    = $clog2(DEPTH) + 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          gat_ready = 1'b0;
    logic          m_tready  = 1'b0;
    logic [AW-1:0] feat_bram_addrb;
    logic [W-1:0]  feat_bram_dout;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tuser;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_bad   = 0;

    gat_feat_reader #(
        .NUM_SUBGRAPHS     (NSG),
        .NUM_FEATURE_OUT   (NFO),
        .NEW_FEATURE_WIDTH (W),
        .RD_LATENCY        (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .gat_ready       (gat_ready),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .m_tuser         (m_tuser),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // BRAM model: two registered stages on the address
    logic [AW-1:0] p0 = '0;
    logic [AW-1:0] p1 = '0;
    always @(posedge clk) begin
        p0 <= feat_bram_addrb;
        p1 <= p0;
    end
    assign feat_bram_dout = 32'hA000_0000 + {28'd0, p1[AW-1:2]};

    // Output monitor: a word seen with valid&ready at the falling edge transfers on the next rising edge
    logic [W-1:0]  q_data[$];
    logic          q_last[$];
    logic          q_user[$];
    int            q_cyc[$];
    logic [AW-1:0] a_q[$];
    int            cyc      = 0;
    int            done_cnt = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata);
                q_last.push_back(m_tlast);
                q_user.push_back(m_tuser);
                q_cyc.push_back(cyc);
            end
            if (done) done_cnt = done_cnt + 1;
            if (busy && (a_q.size() == 0 || a_q[$] != feat_bram_addrb)) a_q.push_back(feat_bram_addrb);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_user(input int i);
`ifdef GAT_FEAT_READER_ROWEND_EN
        return (i % NFO) == (NFO - 1);
`else
        return (i < 0);
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        q_user.delete();
        q_cyc.delete();
        a_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_arrive"}, 64'(q_data.size() >= n), 64'd1);
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_count"}, 64'(q_data.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < q_data.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(32'hA000_0000 + i));
            check_eq($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == DEPTH - 1));
            check_eq($sformatf("%s_user%0d", tag, i), 64'(q_user[i]), 64'(exp_user(i)));
        end
        check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int zero_bad;
        int stall_bad;
        logic [AW-1:0] addr_mid;

        // Reset behaviour
        tick(3);
        check_eq("rst_outputs", {21'd0, busy, done, m_tvalid, m_tlast, m_tuser, feat_bram_addrb, m_tdata}, 64'd0);
        rst_n    = 1'b1;
        zero_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if ({busy, done, m_tvalid, m_tlast, m_tuser, feat_bram_addrb, m_tdata} !== '0) zero_bad++;
        end
        check_eq("idle_outputs_20cyc", 64'(zero_bad), 64'd0);

        // Full read with the sink always ready
        clear_mon();
        gat_ready = 1'b1;
        m_tready  = 1'b1;
        pulse_start();
        wait_words("full", DEPTH, 200);
        tick(3);
        check_stream("full");
        if (q_cyc.size() == DEPTH)
            check_eq("full_consecutive", 64'(q_cyc[DEPTH-1] - q_cyc[0]), 64'(DEPTH - 1));
        check_eq("full_addr_count", 64'(a_q.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < a_q.size(); i++)
            check_eq($sformatf("full_addr%0d", i), 64'(a_q[i]), 64'(4 * i));

        // Backpressure after three words
        clear_mon();
        pulse_start();
        wait_words("bp_pre", 3, 100);
        m_tready  = 1'b0;
        stall_bad = 0;
        addr_mid  = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!m_tvalid || m_tdata !== 32'hA000_0003) stall_bad++;
            if (i == 5) addr_mid = feat_bram_addrb;
        end
        check_eq("bp_hold_data", 64'(stall_bad), 64'd0);
        check_eq("bp_no_issue", 64'(feat_bram_addrb), 64'(addr_mid));
        check_eq("bp_max_held", 64'(feat_bram_addrb <= AW'(24)), 64'd1);
        check_eq("bp_delivered_in_stall", 64'(q_data.size()), 64'd3);
        m_tready = 1'b1;
        wait_words("bp", DEPTH, 200);
        tick(3);
        check_stream("bp");

        // gat_ready gate
        clear_mon();
        gat_ready = 1'b0;
        pulse_start();
        check_eq("gate_busy", 64'(busy), 64'd1);
        zero_bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (feat_bram_addrb !== '0 || m_tvalid !== 1'b0) zero_bad++;
        end
        check_eq("gate_hold", 64'(zero_bad), 64'd0);
        gat_ready = 1'b1;
        wait_words("gate", DEPTH, 200);
        tick(3);
        check_stream("gate");

        // Reset in the middle of a stream
        clear_mon();
        pulse_start();
        wait_words("mrst_pre", 5, 100);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_outputs", {21'd0, busy, done, m_tvalid, m_tlast, m_tuser, feat_bram_addrb, m_tdata}, 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        clear_mon();
        pulse_start();
        wait_words("mrst_first", 1, 100);
        if (q_data.size() > 0)
            check_eq("mrst_first_word", 64'(q_data[0]), 64'h0000_0000_A000_0000);
        wait_words("mrst", DEPTH, 200);
        tick(3);
        check_stream("mrst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
